// File: rtl/z80_io_initiator.sv
// Z80 I/O bus initiator: runs one IN/OUT cycle (T1/T2/TW/T3) per CMD write from a Wishbone slave.
// Optional Z80_WAIT_TIMEOUT_EN aborts cycles stuck in external wait for 16'hFFFF clocks.
module z80_io_initiator #(
    parameter logic [31:0] BASE_ADDRESS   = 32'h3000_0100,
    parameter logic [31:0] CMD_ADDRESS    = BASE_ADDRESS,
    parameter logic [31:0] WDATA_ADDRESS  = BASE_ADDRESS + 32'd4,
    parameter logic [31:0] RDATA_ADDRESS  = BASE_ADDRESS + 32'd8,
    parameter logic [31:0] STATUS_ADDRESS = BASE_ADDRESS + 32'd12,
    parameter int unsigned TSTATE_DIV     = 8,
    parameter int unsigned WAIT_STATES    = 1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [7:0]  z80_address_bus,
    output logic [7:0]  z80_data_bus_out,
    input  logic [7:0]  z80_data_bus_in,
    output logic        z80_bus_dir,
    output logic        z80_ioreq_b,
    output logic        z80_read_strobe_b,
    output logic        z80_write_strobe_b,
    output logic        z80_m1,
    input  logic        z80_wait_b,
    input  logic        wb_cyc_in,
    input  logic        wb_stb_in,
    input  logic        wb_we_in,
    input  logic [31:0] wb_addr_in,
    input  logic [31:0] wb_data_in,
    output logic        wb_ack_out,
    output logic [31:0] wb_data_out,
    output logic        irq_out
);

    localparam int unsigned CW  = $clog2(TSTATE_DIV);
    localparam int unsigned TWW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TSTATE_DIV - 1);
    localparam logic [TWW-1:0] TW_LAST  = TWW'(WAIT_STATES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_TW,
        S_T3,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]  cnt;
    logic           tick;
    logic [TWW-1:0] tw_cnt, tw_cnt_next;
    logic           extra_tw, extra_tw_next;
    logic           wait_meta, wait_sync;

    logic [7:0]     cmd_port;
    logic           cmd_dir;
    logic [7:0]     wdata_reg;
    logic [7:0]     rdata_reg;
    logic           done_flag;
    logic           overrun_flag;
    logic           timeout_flag;
    logic           abort;

    logic           wb_req, wb_hit;
    logic           wr_cmd, wr_wdata, wr_status;
    logic           start, busy, cyc_dir;
    logic           active_next, strobe_next, capture;
    logic [31:0]    rd_mux;
    logic           unused_wb_bits;

    assign z80_m1 = 1'b1;
    assign unused_wb_bits = ^wb_data_in[31:9];

    // Wishbone decode
    assign wb_req    = wb_cyc_in & wb_stb_in & ~wb_ack_out;
    assign wb_hit    = (wb_addr_in == CMD_ADDRESS)   || (wb_addr_in == WDATA_ADDRESS) ||
                       (wb_addr_in == RDATA_ADDRESS) || (wb_addr_in == STATUS_ADDRESS);
    assign wr_cmd    = wb_req & wb_we_in & (wb_addr_in == CMD_ADDRESS);
    assign wr_wdata  = wb_req & wb_we_in & (wb_addr_in == WDATA_ADDRESS);
    assign wr_status = wb_req & wb_we_in & (wb_addr_in == STATUS_ADDRESS);

    assign start   = wr_cmd && (state == S_IDLE);
    assign busy    = (state == S_T1) || (state == S_T2) || (state == S_TW) || (state == S_T3);
    assign cyc_dir = start ? wb_data_in[8] : cmd_dir;
    assign tick    = (cnt == CNT_LAST);
    assign capture = (state == S_T3) && tick && !cmd_dir;

    assign active_next = (state_next == S_T1) || (state_next == S_T2) ||
                         (state_next == S_TW) || (state_next == S_T3);
    assign strobe_next = (state_next == S_T2) || (state_next == S_TW) || (state_next == S_T3);

`ifdef Z80_WAIT_TIMEOUT_EN
    logic [15:0] to_cnt;

    assign abort = (state == S_TW) && extra_tw && (to_cnt == 16'hFFFF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt       <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if ((state == S_TW) && extra_tw)
                to_cnt <= to_cnt + 1'b1;
            else
                to_cnt <= '0;
            if (abort)
                timeout_flag <= 1'b1;
            else if (wr_status && wb_data_in[3])
                timeout_flag <= 1'b0;
        end
    end
`else
    assign abort        = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    always_comb begin
        state_next    = state;
        tw_cnt_next   = tw_cnt;
        extra_tw_next = extra_tw;
        case (state)
            S_IDLE: if (start) state_next = S_T1;
            S_T1:   if (tick) state_next = S_T2;
            S_T2: begin
                if (tick) begin
                    state_next    = S_TW;
                    tw_cnt_next   = '0;
                    extra_tw_next = 1'b0;
                end
            end
            S_TW: begin
                if (abort) begin
                    state_next = S_DONE;
                end else if (tick) begin
                    // Once the programmed TWs are used up, each further TW is decided by WAIT
                    if (tw_cnt != TW_LAST)
                        tw_cnt_next = tw_cnt + 1'b1;
                    else if (!wait_sync)
                        extra_tw_next = 1'b1;
                    else
                        state_next = S_T3;
                end
            end
            S_T3:   if (tick) state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            tw_cnt   <= '0;
            extra_tw <= 1'b0;
        end else begin
            state    <= state_next;
            tw_cnt   <= tw_cnt_next;
            extra_tw <= extra_tw_next;
            if ((state_next != state) || tick)
                cnt <= '0;
            else if (state != S_IDLE)
                cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_meta <= 1'b1;
            wait_sync <= 1'b1;
        end else begin
            wait_meta <= z80_wait_b;
            wait_sync <= wait_meta;
        end
    end

    // Bus outputs are registered from the next state so they switch on the same edge as the FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z80_address_bus    <= '0;
            z80_data_bus_out   <= '0;
            z80_bus_dir        <= 1'b0;
            z80_ioreq_b        <= 1'b1;
            z80_read_strobe_b  <= 1'b1;
            z80_write_strobe_b <= 1'b1;
            irq_out            <= 1'b0;
        end else begin
            z80_bus_dir        <= active_next & cyc_dir;
            z80_ioreq_b        <= ~strobe_next;
            z80_read_strobe_b  <= ~(strobe_next & ~cyc_dir);
            z80_write_strobe_b <= ~(strobe_next & cyc_dir);
            irq_out            <= (state_next == S_DONE);
            if (start) begin
                z80_address_bus  <= wb_data_in[7:0];
                z80_data_bus_out <= wb_data_in[8] ? wdata_reg : 8'h00;
            end else if (state == S_DONE) begin
                z80_address_bus  <= '0;
                z80_data_bus_out <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_port     <= '0;
            cmd_dir      <= 1'b0;
            wdata_reg    <= '0;
            rdata_reg    <= '0;
            done_flag    <= 1'b0;
            overrun_flag <= 1'b0;
        end else begin
            if (start) begin
                cmd_port <= wb_data_in[7:0];
                cmd_dir  <= wb_data_in[8];
            end
            if (wr_wdata)
                wdata_reg <= wb_data_in[7:0];
            if (capture)
                rdata_reg <= z80_data_bus_in;
            if (state_next == S_DONE)
                done_flag <= 1'b1;
            else if (wr_status && wb_data_in[1])
                done_flag <= 1'b0;
            if (wr_cmd && (state != S_IDLE))
                overrun_flag <= 1'b1;
            else if (wr_status && wb_data_in[2])
                overrun_flag <= 1'b0;
        end
    end

    always_comb begin
        rd_mux = '0;
        if (wb_addr_in == CMD_ADDRESS)
            rd_mux = {23'd0, cmd_dir, cmd_port};
        else if (wb_addr_in == WDATA_ADDRESS)
            rd_mux = {24'd0, wdata_reg};
        else if (wb_addr_in == RDATA_ADDRESS)
            rd_mux = {24'd0, rdata_reg};
        else if (wb_addr_in == STATUS_ADDRESS)
            rd_mux = {28'd0, timeout_flag, overrun_flag, done_flag, busy};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_ack_out  <= 1'b0;
            wb_data_out <= '0;
        end else begin
            wb_ack_out  <= wb_req & wb_hit;
            wb_data_out <= (wb_req & wb_hit & ~wb_we_in) ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_z80_io_initiator.sv
// Self-checking bench for z80_io_initiator: directed and randomized IN/OUT cycles against a timing/register model.
module tb_z80_io_initiator;

    localparam int unsigned DIV = 4;
    localparam int unsigned WS  = 1;
    localparam logic [31:0] BASE     = 32'h3000_0100;
    localparam logic [31:0] A_CMD    = BASE;
    localparam logic [31:0] A_WDATA  = BASE + 32'd4;
    localparam logic [31:0] A_RDATA  = BASE + 32'd8;
    localparam logic [31:0] A_STATUS = BASE + 32'd12;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  z80_address_bus;
    logic [7:0]  z80_data_bus_out;
    logic [7:0]  z80_data_bus_in = 8'h00;
    logic        z80_bus_dir;
    logic        z80_ioreq_b;
    logic        z80_read_strobe_b;
    logic        z80_write_strobe_b;
    logic        z80_m1;
    logic        z80_wait_b = 1'b1;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_we = 1'b0;
    logic [31:0] wb_addr = '0;
    logic [31:0] wb_wdat = '0;
    logic        wb_ack;
    logic [31:0] wb_rdat;
    logic        irq_out;

    int errors = 0;
    int checks = 0;
    logic [7:0] m_rdata = 8'h00;

    z80_io_initiator #(
        .BASE_ADDRESS(BASE),
        .TSTATE_DIV(DIV),
        .WAIT_STATES(WS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .z80_address_bus(z80_address_bus),
        .z80_data_bus_out(z80_data_bus_out),
        .z80_data_bus_in(z80_data_bus_in),
        .z80_bus_dir(z80_bus_dir),
        .z80_ioreq_b(z80_ioreq_b),
        .z80_read_strobe_b(z80_read_strobe_b),
        .z80_write_strobe_b(z80_write_strobe_b),
        .z80_m1(z80_m1),
        .z80_wait_b(z80_wait_b),
        .wb_cyc_in(wb_cyc),
        .wb_stb_in(wb_stb),
        .wb_we_in(wb_we),
        .wb_addr_in(wb_addr),
        .wb_data_in(wb_wdat),
        .wb_ack_out(wb_ack),
        .wb_data_out(wb_rdat),
        .irq_out(irq_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = a; wb_wdat = d;
        do begin
            @(negedge clk);
            n++;
        end while (!wb_ack && n < 8);
        check("wb_write_ack", {31'd0, wb_ack}, 32'd1);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        int n = 0;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = a;
        do begin
            @(negedge clk);
            n++;
        end while (!wb_ack && n < 8);
        check("wb_read_ack", {31'd0, wb_ack}, 32'd1);
        d = wb_rdat;
        wb_cyc = 1'b0; wb_stb = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        wb_read(a, d);
        check(tag, d, exp);
    endtask

    // One complete IN/OUT cycle; WAIT is pulled low for len clks starting s clks after ioreq falls.
    task automatic run_io(input string tag, input logic [7:0] port, input logic dir,
                          input logic [7:0] wd, input logic [7:0] din, input int s, input int len);
        int idx, i0, lat, n_io, n_rd, n_wr, n_dir, n_irq, extra, post, tstates;
        logic addr_ok, data_ok;
        // WAIT reaches the FSM two clks after it changes; each final-TW end samples it
        extra = 0;
        while (len > 0 && ((1 + WS + extra) * DIV - 3) >= s &&
               ((1 + WS + extra) * DIV - 3) < s + len)
            extra++;
        tstates = 3 + WS + extra;

        z80_data_bus_in = din;
        wb_write(A_WDATA, {24'd0, wd});
        wb_write(A_CMD, {23'd0, dir, port});
        idx = 0; i0 = -1; lat = -1; post = 0;
        n_io = 0; n_rd = 0; n_wr = 0; n_dir = 0; n_irq = 0;
        addr_ok = 1'b1; data_ok = 1'b1;
        while (idx < 400 && post < 3) begin
            if (irq_out) begin
                n_irq++;
                if (lat < 0) lat = idx;
            end
            if (lat >= 0) post++;
            if (!z80_ioreq_b) n_io++;
            if (!z80_read_strobe_b) n_rd++;
            if (!z80_write_strobe_b) n_wr++;
            if (z80_bus_dir) n_dir++;
            if ((lat < 0 || idx == lat) && z80_address_bus !== port) addr_ok = 1'b0;
            if (z80_bus_dir && z80_data_bus_out !== wd) data_ok = 1'b0;
            if (!z80_ioreq_b && i0 < 0) i0 = idx;
            if (i0 >= 0) z80_wait_b = !((idx - i0) >= s && (idx - i0) < s + len);
            @(negedge clk);
            idx++;
        end
        z80_wait_b = 1'b1;
        if (!dir) m_rdata = din;

        check({tag, "_latency"}, 32'(lat), 32'(tstates * DIV));
        check({tag, "_ioreq_low"}, 32'(n_io), 32'((tstates - 1) * DIV));
        check({tag, "_rd_low"}, 32'(n_rd), dir ? 32'd0 : 32'((tstates - 1) * DIV));
        check({tag, "_wr_low"}, 32'(n_wr), dir ? 32'((tstates - 1) * DIV) : 32'd0);
        check({tag, "_bus_dir"}, 32'(n_dir), dir ? 32'(tstates * DIV) : 32'd0);
        check({tag, "_irq_pulses"}, 32'(n_irq), 32'd1);
        check({tag, "_addr_stable"}, {31'd0, addr_ok}, 32'd1);
        check({tag, "_data_out"}, {31'd0, data_ok}, 32'd1);
        check({tag, "_addr_idle"}, {24'd0, z80_address_bus}, 32'd0);
        read_check({tag, "_status"}, A_STATUS, 32'h2);
        read_check({tag, "_rdata"}, A_RDATA, {24'd0, m_rdata});
        read_check({tag, "_cmd"}, A_CMD, {23'd0, dir, port});
        wb_write(A_STATUS, 32'h2);
        read_check({tag, "_status_clr"}, A_STATUS, 32'h0);
    endtask

    initial begin
        logic [7:0] r_port, r_wd, r_din;
        logic       r_dir;
        int         r_s, r_len, n;
        logic       got_ack;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_outputs",
              {8'd0, z80_address_bus, z80_data_bus_out, z80_bus_dir, z80_ioreq_b,
               z80_read_strobe_b, z80_write_strobe_b, z80_m1, wb_ack, irq_out, 1'b0},
              {8'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        check("reset_wb_data", wb_rdat, 32'd0);
        read_check("reset_status", A_STATUS, 32'h0);
        read_check("reset_rdata", A_RDATA, 32'h0);
        read_check("reset_cmd", A_CMD, 32'h0);

        // Directed cycles from the plan
        run_io("out42", 8'h42, 1'b1, 8'h5A, 8'h00, 0, 0);
        run_io("in10", 8'h10, 1'b0, 8'h00, 8'hA5, 0, 0);
        run_io("wait10", 8'h37, 1'b0, 8'h00, 8'h6C, 2, 10);
        read_check("wdata_readback", A_WDATA, 32'h00);

        // Unmapped address must never be acknowledged
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = BASE + 32'd16; wb_wdat = 32'h1FF;
        got_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (wb_ack) got_ack = 1'b1;
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        check("unmapped_no_ack", {31'd0, got_ack}, 32'd0);
        check("unmapped_no_start", {31'd0, z80_ioreq_b}, 32'd1);

        // CMD while busy is ignored and flags overrun
        z80_data_bus_in = 8'h3C;
        wb_write(A_WDATA, 32'h33);
        wb_write(A_CMD, {23'd0, 1'b0, 8'h21});
        wb_write(A_CMD, {23'd0, 1'b1, 8'h99});
        check("overrun_addr", {24'd0, z80_address_bus}, 32'h21);
        n = 0;
        while (!irq_out && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("overrun_irq_seen", {31'd0, irq_out}, 32'd1);
        m_rdata = 8'h3C;
        read_check("overrun_status", A_STATUS, 32'h6);
        read_check("overrun_cmd", A_CMD, 32'h021);
        read_check("overrun_rdata", A_RDATA, {24'd0, m_rdata});
        wb_write(A_STATUS, 32'h4);
        read_check("overrun_clr", A_STATUS, 32'h2);
        wb_write(A_STATUS, 32'h2);
        read_check("overrun_clr_done", A_STATUS, 32'h0);

        // Reset in the middle of T2
        wb_write(A_WDATA, 32'h5A);
        wb_write(A_CMD, {23'd0, 1'b1, 8'h77});
        repeat (DIV + 1) @(negedge clk);
        check("midT2_active", {30'd0, z80_ioreq_b, z80_bus_dir}, 32'b01);
        reset = 1'b1;
        #1;
        check("midT2_reset_outputs",
              {24'd0, z80_ioreq_b, z80_read_strobe_b, z80_write_strobe_b, z80_bus_dir,
               z80_address_bus[3:0]},
              {24'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0});
        @(negedge clk);
        reset = 1'b0;
        m_rdata = 8'h00;
        read_check("midT2_status", A_STATUS, 32'h0);
        run_io("after_reset", 8'hC3, 1'b1, 8'h81, 8'h00, 0, 0);

        // Randomized cycles with random WAIT windows
        for (int i = 0; i < 8; i++) begin
            r_port = 8'($urandom);
            r_dir  = 1'($urandom_range(0, 1));
            r_wd   = 8'($urandom);
            r_din  = 8'($urandom);
            r_s    = int'($urandom_range(0, 6));
            r_len  = int'($urandom_range(0, 14));
            run_io($sformatf("rand%0d", i), r_port, r_dir, r_wd, r_din, r_s, r_len);
        end

`ifdef Z80_WAIT_TIMEOUT_EN
        // WAIT held low forever: cycle aborts, RDATA keeps its old value
        z80_data_bus_in = 8'hEE;
        z80_wait_b = 1'b0;
        wb_write(A_CMD, {23'd0, 1'b0, 8'h55});
        n = 0;
        while (!irq_out && n < 70000) begin
            @(negedge clk);
            n++;
        end
        check("timeout_irq_seen", {31'd0, irq_out}, 32'd1);
        check("timeout_wait_clks", {31'd0, (n > 65535 && n < 65535 + 4 * DIV * (WS + 3))}, 32'd1);
        z80_wait_b = 1'b1;
        read_check("timeout_status", A_STATUS, 32'hA);
        read_check("timeout_rdata", A_RDATA, {24'd0, m_rdata});
        wb_write(A_STATUS, 32'hA);
        read_check("timeout_clr", A_STATUS, 32'h0);
`else
        read_check("no_timeout_bit", A_STATUS, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
